inst_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the pipeline core.
- Accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit instructions, and writes them sequentially into the instruction memory write port.
- Holds the core in reset until the load completes, then releases it so fetch starts at PC 0.

---
 rtl/inst_loader_pkg.sv | 20 ++
 rtl/inst_loader_byte_assembler.sv | 33 +++
 rtl/inst_loader.sv | 124 ++++++++++++
 tb/tb_inst_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
// Optional checksum byte is enabled by defining LOADER_CHECKSUM_EN
// (left undefined by default, giving the plain length+data frame).
package inst_loader_pkg;

    // Width of one core instruction word.
    localparam int instWidth = 32;

    // Loader state encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects four stream bytes into one little-endian instruction word.
// word_valid is raised in the same cycle the fourth byte is presented so
// the parent can register the write strobe one cycle after the transfer.
module inst_loader_byte_assembler
    import inst_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 word_valid,
    output logic [instWidth-1:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    // Byte position within the word; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_data, shreg[23:8]};
        end
    end

    // Shifting right leaves the first byte of the word in bits [7:0].
    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream, writes the
// assembled words into instruction memory from address 0 and then releases
// the core from reset. Defining LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the core is released.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_wena,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [instWidth-1:0]  imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t               state;
    logic [7:0]           len_lo;
    logic [15:0]          len;
    logic [15:0]          word_cnt;
    logic                 xfer;
    logic                 byte_valid;
    logic                 word_valid;
    logic [instWidth-1:0] word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready   = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CHK);
    assign xfer       = in_valid && in_ready;
    assign byte_valid = xfer && (state == DATA);

    inst_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Frame-parsing FSM with registered memory-write and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            len_lo     <= '0;
            len        <= '0;
            word_cnt   <= '0;
            imem_wena  <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_wena <= 1'b0;
            // Status follows the state one cycle later, so DONE is seen only
            // after the final write strobe has completed.
            core_rst  <= (state == DONE);
            load_done <= (state == DONE);
            load_err  <= (state == ERROR);
            case (state)
                IDLE: state <= LEN_LO;
                LEN_LO: if (xfer) begin
                    len_lo <= in_data;
`ifdef LOADER_CHECKSUM_EN
                    csum   <= in_data;
`endif
                    state  <= LEN_HI;
                end
                LEN_HI: if (xfer) begin
                    len <= {in_data, len_lo};
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ in_data;
`endif
                    if ({in_data, len_lo} == 16'd0)
                        state <= END_STATE;
                    else if (int'({in_data, len_lo}) > MAX_WORDS)
                        state <= ERROR;
                    else
                        state <= DATA;
                end
                DATA: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ in_data;
`endif
                    if (word_valid) begin
                        imem_wena  <= 1'b1;
                        imem_waddr <= word_cnt[ADDR_WIDTH-1:0];
                        imem_wdata <= word;
                        word_cnt   <= word_cnt + 16'd1;
                        if (word_cnt == len - 16'd1)
                            state <= END_STATE;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: if (xfer) begin
                    state <= (in_data == csum) ? DONE : ERROR;
                end
`endif
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed frames plus randomized
// programs and gaps, compared against a frame-level reference model.
module tb_inst_loader;

    localparam int AW   = 8;
    localparam int MAXW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_wena;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          load_done;
    logic          load_err;

    inst_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_wena  (imem_wena),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed behaviour, recorded away from the active edge.
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          done_cyc = -1;
    int          err_cyc  = -1;

    always @(negedge clk) begin
        if (imem_wena) begin
            wa_q.push_back(int'(imem_waddr));
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
        end
        if (load_done && done_cyc < 0) done_cyc = cyc;
        if (load_err && err_cyc < 0) err_cyc = cyc;
    end

    // Stimulus state.
    logic [31:0] prog_q[$];
    logic [7:0]  stream_q[$];
    int          xc_q[$];

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),   32'd0);
        check("rst_wena",      32'(imem_wena),  32'd0);
        check("rst_waddr",     32'(imem_waddr), 32'd0);
        check("rst_wdata",     imem_wdata,      32'd0);
        check("rst_core_rst",  32'(core_rst),   32'd0);
        check("rst_load_done", 32'(load_done),  32'd0);
        check("rst_load_err",  32'(load_err),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    // Offer one byte after 'gap' idle cycles; record the transfer cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 40 && !accepted; k++) begin
            if (in_ready) begin
                xc_q.push_back(cyc + 1);
                accepted = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!accepted) check("byte_accept_timeout", 32'(accepted), 32'd1);
    endtask

    // Reset, stream a frame for prog_q with length n, then compare results
    // with what the frame rules say must happen.
    task automatic run_load(input string name, input int n, input int glo,
                            input int ghi, input bit bad_chk);
        int  nw;
        int  last;
        int  nchk;
        bit  exp_err;
        logic [7:0] x;
        do_reset();
        stream_q.delete();
        xc_q.delete();
        stream_q.push_back(n[7:0]);
        stream_q.push_back(n[15:8]);
        if (n <= MAXW)
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++)
                    stream_q.push_back(prog_q[i][8*b +: 8]);
        exp_err = (n > MAXW);
`ifdef LOADER_CHECKSUM_EN
        if (n <= MAXW) begin
            x = 8'h00;
            foreach (stream_q[i]) x = x ^ stream_q[i];
            stream_q.push_back(x ^ {7'b0, bad_chk});
            exp_err = bad_chk;
        end
`else
        x = 8'h00;
`endif
        foreach (stream_q[i]) send_byte(stream_q[i], int'($urandom_range(ghi, glo)));
        repeat (3) @(negedge clk);

        nw   = (n <= MAXW) ? n : 0;
        last = xc_q[xc_q.size() - 1];
        check({name, "_nwrites"}, 32'(wa_q.size()), 32'(nw));
        nchk = (wa_q.size() < nw) ? wa_q.size() : nw;
        for (int i = 0; i < nchk; i++) begin
            check($sformatf("%s_addr%0d", name, i), 32'(wa_q[i]), 32'(i));
            check($sformatf("%s_data%0d", name, i), wd_q[i], prog_q[i]);
            check($sformatf("%s_wcyc%0d", name, i), 32'(wc_q[i]), 32'(xc_q[2 + 4*i + 3]));
        end
        if (exp_err) begin
            check({name, "_err_cyc"},  32'(err_cyc),  32'(last + 1));
            check({name, "_done_cyc"}, 32'(done_cyc), 32'hFFFF_FFFF);
            check({name, "_core_rst"}, 32'(core_rst), 32'd0);
        end else begin
            check({name, "_done_cyc"}, 32'(done_cyc), 32'(last + 1));
            check({name, "_err_cyc"},  32'(err_cyc),  32'hFFFF_FFFF);
            check({name, "_core_rst"}, 32'(core_rst), 32'd1);
        end
        // Further bytes must be refused.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            check({name, "_post_ready"}, 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_post_nwrites"}, 32'(wa_q.size()), 32'(nw));
    endtask

    initial begin
        int n;
        @(negedge clk);

        // Two-word program, back-to-back then with 3-cycle gaps.
        prog_q = '{32'h0050_0093, 32'h0010_0113};
        run_load("two_words", 2, 0, 0, 1'b0);
        run_load("two_words_gap", 2, 3, 3, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        run_load("two_words_badchk", 2, 0, 0, 1'b1);
`endif

        // Empty program and oversize program.
        prog_q.delete();
        run_load("empty", 0, 0, 0, 1'b0);
        run_load("too_long", 257, 0, 0, 1'b0);

        // Reset mid-load, with a byte offered during the reset edge.
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        prog_q = '{32'h1234_5678};
        run_load("midload_rst", 1, 0, 0, 1'b0);

        // Largest legal program: address must reach MAX_WORDS-1 without wrap.
        prog_q.delete();
        for (int i = 0; i < MAXW; i++) prog_q.push_back($urandom);
        run_load("max_len", MAXW, 0, 0, 1'b0);

        // Randomized programs, gaps and checksum corruption.
        for (int t = 0; t < 8; t++) begin
            prog_q.delete();
            n = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) prog_q.push_back($urandom);
            run_load($sformatf("rand%0d", t), n, 0, 3, 1'($urandom_range(1)));
        end
        prog_q.delete();
        run_load("rand_too_long", int'($urandom_range(65535, 257)), 0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
